chip8_pixel_renderer: RTL and testbench

- Converts the 64x32 monochrome CHIP-8 framebuffer into 4-bit-per-channel RGB for the VGA output stage.
- Consumes the pixel strobe and the horizontal/vertical raster counters, and scales each CHIP-8 pixel to a 10x10 block.
- The image is 640x320, centred vertically in the 640x480 active area.
- During horizontal blanking, fetches the next line's 8 framebuffer bytes from display RAM into a row register.

---
 rtl/chip8_pixel_renderer.sv | 209 ++++++++++++++++++++
 tb/tb_chip8_pixel_renderer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/chip8_pixel_renderer.sv
// chip8_pixel_renderer
// Turns the 64x32 monochrome CHIP-8 framebuffer into 4-bit-per-channel RGB
// for the VGA stage. Each CHIP-8 pixel becomes a SCALE x SCALE block. The
// 640x320 image sits vertically centred in the 640x480 active area. During
// horizontal blanking the next line's eight framebuffer bytes are fetched
// from display RAM into a 64-bit row register.
//
// Ports:
//   clk_i          system clock (only clock)
//   rst_ni         synchronous active-low reset
//   pixel_tick_i   one-clk strobe; h/v counts are valid and advance per strobe
//   h_count_i      horizontal raster position
//   v_count_i      vertical raster position
//   fb_rd_en_o     display RAM read enable
//   fb_addr_o      display RAM byte address (row*8 + byte)
//   fb_rd_data_i   RAM read data, valid one clk after fb_rd_en_o
//   vga_r_o/g/b    colour outputs, one tick of latency
//   frame_tick_o   one-clk pulse at the start of vertical blanking
module chip8_pixel_renderer #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_LAST       = 525,
  parameter int unsigned V_OFFSET     = 80,
  parameter int unsigned SCALE        = 10,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] BORDER_COLOR = 12'h000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pixel_tick_i,
  input  logic [15:0] h_count_i,
  input  logic [15:0] v_count_i,
  output logic        fb_rd_en_o,
  output logic [7:0]  fb_addr_o,
  input  logic [7:0]  fb_rd_data_i,
  output logic [3:0]  vga_r_o,
  output logic [3:0]  vga_g_o,
  output logic [3:0]  vga_b_o,
  output logic        frame_tick_o
);

  localparam int unsigned SW        = $clog2(SCALE + 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  localparam logic [15:0] IMG_FIRST = 16'(V_OFFSET);
  localparam logic [15:0] IMG_END   = 16'(V_OFFSET + 32 * SCALE);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e        state_q;
  logic          fbRdEn_q;
  logic [7:0]    fbAddr_q;
  logic          pend_q;
  logic [2:0]    pendIdx_q;
  logic [63:0]   rowBits_q;
  logic [11:0]   color_q;
  logic          frameTick_q;
  logic          frameSeen_q;

  logic [SW-1:0] pixSub_q, pixSub_d, pixSubCur;
  logic [5:0]    col_q, col_d, colCur;
  logic [SW-1:0] lineSub_q, lineSub_d, lineSubCur;
  logic [4:0]    row_q, row_d, rowCur;
  logic [15:0]   nextV;
  logic          nextInImage;
  logic          lineTick;
  logic [11:0]   colorNext;
  logic [5:0]    capBase;

  // Horizontal position as (column, sub-pixel) without a divider. The
  // counters describe the pixel being sampled this tick; h == 0 forces them
  // to zero so the line always starts aligned. Column saturates at 63 since
  // nothing past the last column is displayed.
  always_comb begin
    pixSubCur = (h_count_i == 16'd0) ? '0 : pixSub_q;
    colCur    = (h_count_i == 16'd0) ? '0 : col_q;
    pixSub_d  = pixSub_q;
    col_d     = col_q;
    if (pixel_tick_i) begin
      if (pixSubCur == SUB_LAST) begin
        pixSub_d = '0;
        col_d    = (colCur == 6'd63) ? colCur : colCur + 6'd1;
      end else begin
        pixSub_d = pixSubCur + 1'b1;
        col_d    = colCur;
      end
    end
  end

  // Vertical position of the line that follows the current one, tracked
  // once per line at the fetch trigger point. The counters re-align whenever
  // the next line is the first image line, which also covers the wrap case.
  always_comb begin
    nextV       = (v_count_i == 16'(V_LAST)) ? 16'd0 : v_count_i + 16'd1;
    nextInImage = (nextV >= IMG_FIRST) && (nextV < IMG_END);
    lineTick    = pixel_tick_i && (h_count_i == 16'(H_ACTIVE));
    lineSubCur  = (nextV == IMG_FIRST) ? '0 : lineSub_q;
    rowCur      = (nextV == IMG_FIRST) ? '0 : row_q;
    lineSub_d   = lineSub_q;
    row_d       = row_q;
    if (lineTick) begin
      if (lineSubCur == SUB_LAST) begin
        lineSub_d = '0;
        row_d     = (rowCur == 5'd31) ? rowCur : rowCur + 5'd1;
      end else begin
        lineSub_d = lineSubCur + 1'b1;
        row_d     = rowCur;
      end
    end
  end

  // Colour for the sampled raster position; the leftmost screen column maps
  // to the row register MSB.
  always_comb begin
    colorNext = BG_COLOR;
    if ((h_count_i >= 16'(H_ACTIVE)) || (v_count_i >= 16'(V_ACTIVE))) begin
      colorNext = '0;
    end else if ((v_count_i < IMG_FIRST) || (v_count_i >= IMG_END)) begin
      colorNext = BORDER_COLOR;
    end else if (rowBits_q[6'd63 - colCur]) begin
      colorNext = FG_COLOR;
    end else begin
      colorNext = BG_COLOR;
    end
    capBase = 6'd63 - {pendIdx_q, 3'b000};
  end

  // Fetch sequencer: eight back-to-back reads, then one DRAIN cycle so the
  // final byte (one clk behind its request) is captured before going idle.
  // The low address bits double as the byte index within the row.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      fbRdEn_q <= 1'b0;
      fbAddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lineTick && nextInImage) begin
            state_q  <= READ;
            fbRdEn_q <= 1'b1;
            fbAddr_q <= {rowCur, 3'b000};
          end
        end
        READ: begin
          if (fbAddr_q[2:0] == 3'd7) begin
            state_q  <= DRAIN;
            fbRdEn_q <= 1'b0;
          end else begin
            fbAddr_q <= fbAddr_q + 8'd1;
          end
        end
        DRAIN: state_q <= IDLE;
        default: begin
          state_q  <= IDLE;
          fbRdEn_q <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: raster counters, byte capture one clk after each request,
  // registered colour and the once-per-frame pulse. frameSeen_q blocks a
  // repeat pulse until the raster returns to the active lines.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pixSub_q    <= '0;
      col_q       <= '0;
      lineSub_q   <= '0;
      row_q       <= '0;
      pend_q      <= 1'b0;
      pendIdx_q   <= '0;
      rowBits_q   <= '0;
      color_q     <= '0;
      frameTick_q <= 1'b0;
      frameSeen_q <= 1'b0;
    end else begin
      pixSub_q  <= pixSub_d;
      col_q     <= col_d;
      lineSub_q <= lineSub_d;
      row_q     <= row_d;
      pend_q    <= fbRdEn_q;
      pendIdx_q <= fbAddr_q[2:0];
      if (pend_q) begin
        rowBits_q[capBase -: 8] <= fb_rd_data_i;
      end
      if (pixel_tick_i) begin
        color_q <= colorNext;
      end
      frameTick_q <= pixel_tick_i && (v_count_i == 16'(V_ACTIVE)) &&
                     (h_count_i == 16'd0) && !frameSeen_q;
      if (pixel_tick_i) begin
        if ((v_count_i == 16'(V_ACTIVE)) && (h_count_i == 16'd0)) begin
          frameSeen_q <= 1'b1;
        end else if (v_count_i < 16'(V_ACTIVE)) begin
          frameSeen_q <= 1'b0;
        end
      end
    end
  end

  assign fb_rd_en_o   = fbRdEn_q;
  assign fb_addr_o    = fbAddr_q;
  assign vga_r_o      = color_q[11:8];
  assign vga_g_o      = color_q[7:4];
  assign vga_b_o      = color_q[3:0];
  assign frame_tick_o = frameTick_q;

endmodule

// File: tb/tb_chip8_pixel_renderer.sv
// tb_chip8_pixel_renderer
// Self-checking bench for chip8_pixel_renderer. Drives a compressed raster
// (full visible lines on selected rows, only the h=0 tick plus a blanking
// burst elsewhere) with random tick spacing and random RAM updates, and
// compares colour, fetch addresses and frame pulses against a behavioural
// model built from the framebuffer contents with plain arithmetic.
module tb_chip8_pixel_renderer;

  logic        clk = 1'b0;
  logic        rstN;
  logic        pixelTick;
  logic [15:0] hCount;
  logic [15:0] vCount;
  logic        fbRdEn;
  logic [7:0]  fbAddr;
  logic [7:0]  fbRdData;
  logic [3:0]  vgaR, vgaG, vgaB;
  logic        frameTick;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ram [256];
  bit          modelRow [64];
  logic [11:0] prevExp;
  int          expAddr [$];
  int          gotAddr [$];
  int          gotCyc [$];
  int          cycleNum = 0;
  int          frameTotal = 0;

  chip8_pixel_renderer dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .pixel_tick_i (pixelTick),
    .h_count_i    (hCount),
    .v_count_i    (vCount),
    .fb_rd_en_o   (fbRdEn),
    .fb_addr_o    (fbAddr),
    .fb_rd_data_i (fbRdData),
    .vga_r_o      (vgaR),
    .vga_g_o      (vgaG),
    .vga_b_o      (vgaB),
    .frame_tick_o (frameTick)
  );

  always #5 clk = ~clk;

  // Display RAM: data appears one clk after the read request.
  always @(posedge clk) begin
    if (fbRdEn) fbRdData <= ram[fbAddr];
  end

  // Record every read request and frame pulse, sampled mid-cycle.
  always @(negedge clk) begin
    cycleNum = cycleNum + 1;
    if (fbRdEn) begin
      gotAddr.push_back(int'(fbAddr));
      gotCyc.push_back(cycleNum);
    end
    if (frameTick) frameTotal = frameTotal + 1;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] expColor(input int h, input int v);
    if (h >= 640 || v >= 480) return 12'h000;
    if (v < 80 || v >= 400) return 12'h000;
    return modelRow[h / 10] ? 12'hFFF : 12'h000;
  endfunction

  // One pixel strobe at (h, v). The colour must hold its old value up to
  // the strobe and show the new pixel right after it. A strobe at the end
  // of the visible line also updates the model's row snapshot and the
  // expected fetch addresses for the following line.
  task automatic applyStimulus(input int h, input int v);
    logic [11:0] exp;
    int nv, r;
    checkOutput($sformatf("hold h=%0d v=%0d", h, v), {vgaR, vgaG, vgaB}, prevExp);
    exp = expColor(h, v);
    pixelTick = 1'b1;
    hCount = 16'(h);
    vCount = 16'(v);
    @(posedge clk);
    @(negedge clk);
    pixelTick = 1'b0;
    checkOutput($sformatf("color h=%0d v=%0d", h, v), {vgaR, vgaG, vgaB}, exp);
    prevExp = exp;
    if (h == 640) begin
      nv = (v == 525) ? 0 : v + 1;
      if (nv >= 80 && nv < 400) begin
        r = (nv - 80) / 10;
        for (int x = 0; x < 64; x++) modelRow[x] = ram[r * 8 + x / 8][7 - x % 8];
        for (int k = 0; k < 8; k++) expAddr.push_back(r * 8 + k);
      end
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic runLine(input int v, input bit full);
    int frameStart, n;
    frameStart = frameTotal;
    if (v >= 80 && $urandom_range(0, 3) == 0) ram[$urandom_range(8, 255)] = 8'($urandom);
    if (full) begin
      for (int h = 0; h < 640; h++) applyStimulus(h, v);
    end else begin
      applyStimulus(0, v);
    end
    for (int h = 640; h < 656; h++) applyStimulus(h, v);
    checkOutput($sformatf("fetchCount v=%0d", v), gotAddr.size(), expAddr.size());
    n = (gotAddr.size() < expAddr.size()) ? gotAddr.size() : expAddr.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("fetchAddr v=%0d k=%0d", v, i), gotAddr[i], expAddr[i]);
      if (i > 0) checkOutput($sformatf("fetchGap v=%0d k=%0d", v, i), gotCyc[i] - gotCyc[i-1], 1);
    end
    checkOutput($sformatf("frameTick v=%0d", v), frameTotal - frameStart, (v == 480) ? 1 : 0);
    gotAddr.delete();
    gotCyc.delete();
    expAddr.delete();
  endtask

  initial begin
    int r1, r2, found;
    bit isFull;
    rstN = 1'b0;
    pixelTick = 1'b0;
    hCount = '0;
    vCount = '0;
    fbRdData = '0;
    prevExp = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) ram[i] = 8'h00;
    ram[0] = 8'h80;
    ram[7] = 8'h01;
    for (int x = 0; x < 64; x++) modelRow[x] = 1'b0;
    r1 = $urandom_range(92, 250);
    r2 = $urandom_range(251, 398);
    $display("[TB] random full lines %0d and %0d", r1, r2);

    // Reset held for three clocks while strobes keep running.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pixelTick = 1'b1;
      hCount = 16'($urandom_range(0, 639));
      vCount = 16'($urandom_range(80, 399));
      @(negedge clk);
      checkOutput("resetVga", {vgaR, vgaG, vgaB}, 0);
      checkOutput("resetRdEn", fbRdEn, 0);
      checkOutput("resetFrame", frameTick, 0);
    end
    pixelTick = 1'b0;
    rstN = 1'b1;
    @(negedge clk);
    gotAddr.delete();
    gotCyc.delete();

    // Sequential scan through the image, blanking and the wrap point.
    for (int v = 70; v <= 525; v++) begin
      isFull = (v == 80 || v == 85 || v == 89 || v == 90 || v == 91 || v == r1 ||
                v == r2 || v == 399 || v == 400 || v == 479 || v == 480);
      runLine(v, isFull);
    end
    for (int v = 0; v < 79; v++) runLine(v, 1'b0);

    // Reset in the middle of the row 0 fetch: the partial row must vanish.
    applyStimulus(0, 79);
    applyStimulus(640, 79);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (fbRdEn && fbAddr == 8'd3) found = 1;
      else @(negedge clk);
    end
    checkOutput("midFetchK3Seen", found, 1);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("midFetchRdEnDrop", fbRdEn, 0);
    checkOutput("midFetchVga", {vgaR, vgaG, vgaB}, 0);
    checkOutput("midFetchPartialCount", gotAddr.size(), 4);
    rstN = 1'b1;
    @(negedge clk);
    for (int x = 0; x < 64; x++) modelRow[x] = 1'b0;
    prevExp = '0;
    gotAddr.delete();
    gotCyc.delete();
    expAddr.delete();
    runLine(80, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
